// File: rtl/dpa_defs.sv
// Shared widths, frame geometry and scan-out FSM state encoding for the frame-buffer datapath.
package dpa_defs;

  localparam int unsigned AW_DEF    = 20;
  localparam int unsigned DW_DEF    = 24;
  localparam int unsigned LINE_DEF  = 256;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned FRAME_PIX = LINE_DEF * LINE_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous DEPTH x DW pixel FIFO with occupancy count; head word is presented combinationally.
module pix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (cnt_q != FULL_CNT);
    do_pop   = pop && (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out reader: fetches one LINE x LINE frame over req/gnt and streams pixels.
// Optional FB_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module fb_scanout
  import dpa_defs::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LINE  = LINE_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] fb_addr,
  output logic          rd_req,
  output logic [AW-1:0] rd_a,
  input  logic          rd_gnt,
  input  logic [DW-1:0] rd_q,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [DW-1:0] pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          busy,
  output logic          done
`ifdef FB_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned FPIX = LINE * LINE;
  localparam int unsigned CW   = $clog2(FPIX) + 1;
  localparam int unsigned XW   = $clog2(LINE);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned KW   = PW + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(FPIX - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(LINE - 1);
  localparam logic [KW-1:0] CREDITS  = KW'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          inflight_q, inflight_d;

  logic          accept, xfer, last_grant, last_xfer;
  logic [KW-1:0] credit_used;
  logic [DW-1:0] fifo_dout;
  logic [PW:0]   fifo_cnt;
  logic          fifo_empty;

  pix_fifo #(
    .DEPTH(DEPTH),
    .DW   (DW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (inflight_q),
    .din  (rd_q),
    .pop  (xfer),
    .dout (fifo_dout),
    .cnt  (fifo_cnt),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_grant) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credit rule: FIFO occupancy plus the one possible in-flight word never exceeds DEPTH.
  always_comb begin
    credit_used = fifo_cnt + KW'(inflight_q);
    rd_req      = (state_q == FETCH) && (credit_used < CREDITS);
    rd_a        = rd_req ? (base_q + AW'(rd_cnt_q)) : '0;
    busy        = (state_q == FETCH) || (state_q == DRAIN);
    done        = (state_q == DONE);
  end

  always_comb begin
    accept     = rd_req && rd_gnt;
    xfer       = pix_valid && pix_ready;
    last_grant = accept && (rd_cnt_q == LAST_PIX);
    last_xfer  = xfer && (out_cnt_q == LAST_PIX);
    base_d     = base_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = accept;
    if ((state_q == IDLE) && start) begin
      base_d    = fb_addr;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (accept) rd_cnt_d = rd_cnt_q + CW'(1);
      if (xfer) out_cnt_d = out_cnt_q + CW'(1);
    end
  end

  always_comb begin
    pix_valid = !fifo_empty;
    pix_data  = pix_valid ? fifo_dout : '0;
    pix_sof   = pix_valid && (out_cnt_q == '0);
    pix_eol   = pix_valid && (out_cnt_q[XW-1:0] == LAST_X);
  end

`ifdef FB_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == DONE) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: grants push expected pixels, the output monitor pops and compares.
module tb_fb_scanout;

  localparam int unsigned AW   = 20;
  localparam int unsigned DW   = 24;
  localparam int unsigned LINE = 256;
  localparam int unsigned FPIX = LINE * LINE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] fb_addr = '0;
  logic          rd_req;
  logic [AW-1:0] rd_a;
  logic          rd_gnt = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_sof, pix_eol, busy, done;
`ifdef FB_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [AW-1:0] tb_base = '0;
  logic [AW-1:0] exp_a;
  int            gnt_idx = 0;
  int            pix_cnt = 0;
  int            done_cnt = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  fb_scanout #(
    .AW   (AW),
    .DW   (DW),
    .LINE (LINE),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .fb_addr  (fb_addr),
    .rd_req   (rd_req),
    .rd_a     (rd_a),
    .rd_gnt   (rd_gnt),
    .rd_q     (rd_q),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_sof  (pix_sof),
    .pix_eol  (pix_eol),
    .busy     (busy),
    .done     (done)
`ifdef FB_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  // Memory model returns addr[23:0] one cycle after acceptance; expectation comes from the bench's own count.
  always @(posedge clk) begin
    if (!reset && rd_req && rd_gnt) begin
      rd_q <= DW'(rd_a);
      exp_a = tb_base + AW'(gnt_idx);
      sb.push_back('{data: DW'(exp_a), sof: (gnt_idx == 0), eol: ((gnt_idx % LINE) == LINE - 1)});
      gnt_idx++;
    end else begin
      rd_q <= 24'hBADBAD;
    end
  end

  always @(negedge clk) begin
    #2;
    if (!reset && done) done_cnt++;
    if (!reset && pix_valid && pix_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got data=%06h with no expected pixel pending", pix_data);
      end else begin
        e = sb.pop_front();
        if ({pix_data, pix_sof, pix_eol} !== {e.data, e.sof, e.eol}) begin
          errors++;
          $display("FAIL pix_stream: got data=%06h sof=%0b eol=%0b, expected data=%06h sof=%0b eol=%0b",
                   pix_data, pix_sof, pix_eol, e.data, e.sof, e.eol);
        end
      end
      pix_cnt++;
    end
  end

  initial begin
    #1_000_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    gnt_idx = 0;
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    @(negedge clk);
    fb_addr = base;
    tb_base = base;
    gnt_idx = 0;
    sb.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_gnt = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_req, rd_a, pix_valid, pix_data, pix_sof, pix_eol, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b a=%05h v=%0b d=%06h sof=%0b eol=%0b busy=%0b done=%0b, expected all 0",
               rd_req, rd_a, pix_valid, pix_data, pix_sof, pix_eol, busy, done);
    end
`ifdef FB_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt);
    end
`endif
    reset = 1'b0;
    rd_gnt = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_req, pix_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_gnt_ignored: got req=%0b v=%0b busy=%0b, expected 000", rd_req, pix_valid, busy);
    end
  endtask

  task automatic test_full_frame();
    int cyc, first_v, done_at, d0, p0;
    rd_gnt = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    p0 = pix_cnt;
    fb_addr = 20'h10000;
    tb_base = 20'h10000;
    gnt_idx = 0;
    sb.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checks++;
    if ({busy, rd_req, rd_a} !== {1'b1, 1'b1, 20'h10000}) begin
      errors++;
      $display("FAIL first_request: got busy=%0b req=%0b a=%05h, expected busy=1 req=1 a=10000", busy, rd_req, rd_a);
    end
    first_v = -1;
    done_at = -1;
    while (cyc < 65600 && (done_at < 0 || cyc < done_at + 8)) begin
      if (pix_valid && first_v < 0) first_v = cyc;
      if (done && done_at < 0) begin
        done_at = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_on_done: got %0b, expected 0", busy);
        end
        start = 1'b1;
      end else begin
        start = (cyc == 1000);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (first_v !== 3) begin
      errors++;
      $display("FAIL first_valid_latency: got cycle %0d, expected 3", first_v);
    end
    checks++;
    if (done_at !== 65539) begin
      errors++;
      $display("FAIL done_cycle: got cycle %0d, expected 65539", done_at);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    checks++;
    if (pix_cnt - p0 !== int'(FPIX) || sb.size() !== 0) begin
      errors++;
      $display("FAIL frame_pixels: got %0d transferred with %0d pending, expected %0d and 0",
               pix_cnt - p0, sb.size(), FPIX);
    end
    checks++;
    if ({busy, rd_req, pix_valid} !== 3'b000) begin
      errors++;
      $display("FAIL start_in_done_ignored: got busy=%0b req=%0b v=%0b, expected 000", busy, rd_req, pix_valid);
    end
`ifdef FB_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frame_cnt_inc: got %0d, expected 1", frame_cnt);
    end
`endif
  endtask

  task automatic test_gnt_stall();
    int n, p0;
    rd_gnt = 1'b1;
    pix_ready = 1'b1;
    p0 = pix_cnt;
    start_frame(20'h10000);
    n = 0;
    while (gnt_idx < 100 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt_idx !== 100) begin
      errors++;
      $display("FAIL gnt_stall_reach: got %0d grants, expected 100", gnt_idx);
    end
    rd_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rd_req, rd_a} !== {1'b1, 20'h10064}) begin
        errors++;
        $display("FAIL gnt_stall_hold: cycle %0d got req=%0b a=%05h, expected req=1 a=10064", i, rd_req, rd_a);
      end
      @(negedge clk);
    end
    rd_gnt = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (pix_cnt - p0 < 400) begin
      errors++;
      $display("FAIL gnt_stall_resume: got %0d pixels, expected at least 400", pix_cnt - p0);
    end
    do_reset();
  endtask

  task automatic test_ready_stall();
    int n, p0;
    rd_gnt = 1'b1;
    pix_ready = 1'b1;
    p0 = pix_cnt;
    start_frame(20'h10000);
    n = 0;
    while (pix_cnt - p0 < 50 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pix_cnt - p0 !== 50) begin
      errors++;
      $display("FAIL ready_stall_reach: got %0d pixels, expected 50", pix_cnt - p0);
    end
    pix_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({pix_valid, pix_data, pix_sof, pix_eol} !== {1'b1, 24'h010032, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL ready_stall_hold: cycle %0d got v=%0b d=%06h sof=%0b eol=%0b, expected v=1 d=010032 sof=0 eol=0",
                 i, pix_valid, pix_data, pix_sof, pix_eol);
      end
      if (i >= 2) begin
        checks++;
        if (rd_req !== 1'b0) begin
          errors++;
          $display("FAIL ready_stall_credit: cycle %0d got req=%0b, expected 0", i, rd_req);
        end
      end
      @(negedge clk);
    end
    pix_ready = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (pix_cnt - p0 < 300) begin
      errors++;
      $display("FAIL ready_stall_resume: got %0d pixels, expected at least 300", pix_cnt - p0);
    end
    do_reset();
  endtask

  task automatic test_addr_wrap();
    int n;
    bit seen_hi, seen_lo;
    rd_gnt = 1'b1;
    pix_ready = 1'b1;
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    start_frame(20'hFFF00);
    n = 0;
    while (gnt_idx <= 300 && n < 800) begin
      if (rd_req && rd_gnt && gnt_idx == 255) begin
        seen_hi = 1'b1;
        checks++;
        if (rd_a !== 20'hFFFFF) begin
          errors++;
          $display("FAIL wrap_last_addr: got %05h, expected fffff", rd_a);
        end
      end
      if (rd_req && rd_gnt && gnt_idx == 256) begin
        seen_lo = 1'b1;
        checks++;
        if (rd_a !== 20'h00000) begin
          errors++;
          $display("FAIL wrap_first_addr: got %05h, expected 00000", rd_a);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if ({seen_hi, seen_lo} !== 2'b11) begin
      errors++;
      $display("FAIL wrap_reached: got seen=%b, expected 11", {seen_hi, seen_lo});
    end
    repeat (10) @(negedge clk);
    do_reset();
  endtask

  task automatic test_reset_abort();
    int n, d0, p0;
    rd_gnt = 1'b1;
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_frame(20'h10000);
    n = 0;
    while (!(gnt_idx == 300 && rd_req && rd_gnt) && n < 800) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt_idx !== 300) begin
      errors++;
      $display("FAIL abort_reach: got %0d grants, expected 300", gnt_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_req, rd_a, pix_valid, pix_data, pix_sof, pix_eol, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got req=%0b a=%05h v=%0b d=%06h sof=%0b eol=%0b busy=%0b done=%0b, expected all 0",
               rd_req, rd_a, pix_valid, pix_data, pix_sof, pix_eol, busy, done);
    end
    @(negedge clk);
    sb.delete();
    gnt_idx = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, pix_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_discard: got busy=%0b v=%0b, expected 00", busy, pix_valid);
    end
`ifdef FB_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_frame_cnt: got %0d, expected 0", frame_cnt);
    end
`endif
    p0 = pix_cnt;
    start_frame(20'h10000);
    repeat (600) @(negedge clk);
    checks++;
    if (pix_cnt - p0 < 590) begin
      errors++;
      $display("FAIL abort_replay: got %0d pixels, expected at least 590", pix_cnt - p0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_cnt - d0);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gnt_stall();
    test_ready_stall();
    test_addr_wrap();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
